cflog_write_sched: RTL and testbench



---
 rtl/cflog_write_sched.sv | 141 ++++++++++++++
 tb/tb_cflog_write_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cflog_write_sched.sv
// CFLog write scheduler: buffers (src, dest) entries in a small FIFO and writes each
// as two consecutive words into the shared log memory port, with flush and drain handshakes.
module cflog_write_sched #(
    parameter int unsigned LOG_SIZE   = 16'h0100,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        puc,
    input  logic        ent_valid,
    input  logic [15:0] ent_src,
    input  logic [15:0] ent_dest,
    output logic        ent_ready,
    input  logic        sw_req,
    output logic        sw_grant,
    output logic        log_wen,
    output logic [15:0] log_addr,
    output logic [15:0] log_wdata,
    output logic [15:0] log_ptr,
    output logic        flush_req,
    input  logic        flush_ack,
    input  logic        drain_req,
    output logic        drain_done,
    output logic        overflow,
    output logic [2:0]  dbg_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [15:0]   LOG_END = 16'(LOG_SIZE);

    // Handshake: an entry moves only on a cycle where ent_valid & ent_ready are both
    // high; ent_ready depends on registered state only, never on ent_valid.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SW      = 3'd1,
        S_WR_SRC  = 3'd2,
        S_WR_DEST = 3'd3,
        S_FULL    = 3'd4
    } state_t;

    state_t          state_q;
    logic [15:0]     log_ptr_q;
    logic            overflow_q;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [31:0]     head;
    logic            push, pop;

    assign ent_ready = (count_q != DEPTH_C);
    assign push      = ent_valid & ent_ready;
    assign pop       = (state_q == S_WR_DEST);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (puc) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (ent_valid && !ent_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Entry storage carries no reset; the count alone says what is valid.
    always_ff @(posedge clk) begin
        if (!puc && push) begin
            mem_q[wr_ptr_q] <= {ent_src, ent_dest};
        end
    end

    always_ff @(posedge clk) begin
        if (puc) begin
            state_q   <= S_IDLE;
            log_ptr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sw_req) begin
                        state_q <= S_SW;
                    end else if (count_q != '0) begin
                        state_q <= S_WR_SRC;
                    end
                end
                S_SW: begin
                    if (!sw_req) begin
                        state_q <= S_IDLE;
                    end
                end
                S_WR_SRC: begin
                    log_ptr_q <= log_ptr_q + 16'd1;
                    state_q   <= S_WR_DEST;
                end
                S_WR_DEST: begin
                    log_ptr_q <= log_ptr_q + 16'd1;
                    state_q   <= ((log_ptr_q + 16'd1) == LOG_END) ? S_FULL : S_IDLE;
                end
                S_FULL: begin
                    if (flush_ack) begin
                        log_ptr_q <= '0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory-port outputs are a pure decode of the state register.
    assign log_wen    = (state_q == S_WR_SRC) || (state_q == S_WR_DEST);
    assign log_addr   = log_wen ? log_ptr_q : 16'd0;
    assign log_wdata  = (state_q == S_WR_SRC)  ? head[31:16] :
                        (state_q == S_WR_DEST) ? head[15:0]  : 16'd0;
    assign sw_grant   = (state_q == S_SW);
    assign flush_req  = (state_q == S_FULL);
    assign log_ptr    = log_ptr_q;
    assign overflow   = overflow_q;
    assign drain_done = drain_req && (count_q == '0) && (state_q == S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cflog_write_sched.sv
// Bench for cflog_write_sched: directed scenarios plus random traffic, every cycle
// compared against a queue-based behavioural model of the log writer.
module tb_cflog_write_sched;

    localparam int LS    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        puc, ent_valid, sw_req, flush_ack, drain_req;
    logic [15:0] ent_src, ent_dest;
    logic        ent_ready, sw_grant, log_wen, flush_req, drain_done, overflow;
    logic [15:0] log_addr, log_wdata, log_ptr;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    cflog_write_sched #(.LOG_SIZE(LS), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .puc(puc),
        .ent_valid(ent_valid), .ent_src(ent_src), .ent_dest(ent_dest), .ent_ready(ent_ready),
        .sw_req(sw_req), .sw_grant(sw_grant),
        .log_wen(log_wen), .log_addr(log_addr), .log_wdata(log_wdata), .log_ptr(log_ptr),
        .flush_req(flush_req), .flush_ack(flush_ack),
        .drain_req(drain_req), .drain_done(drain_done),
        .overflow(overflow), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pending entries, the word pointer, and what the shared port is doing.
    localparam int M_IDLE = 0, M_SW = 1, M_SRC = 2, M_DEST = 3, M_FULL = 4;
    logic [31:0] exp_q[$];
    int          m_ptr;
    bit          m_ovf;
    int          m_phase;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ptr   = 0;
        m_ovf   = 0;
        m_phase = M_IDLE;
    endtask

    task automatic check_outputs();
        bit          wen;
        logic [15:0] data;
        wen  = (m_phase == M_SRC) || (m_phase == M_DEST);
        data = 16'd0;
        if (m_phase == M_SRC)  data = exp_q[0][31:16];
        if (m_phase == M_DEST) data = exp_q[0][15:0];
        check_eq("ent_ready",  32'(ent_ready),  32'(exp_q.size() < DEPTH));
        check_eq("log_wen",    32'(log_wen),    32'(wen));
        check_eq("log_addr",   32'(log_addr),   wen ? 32'(m_ptr) : 32'd0);
        check_eq("log_wdata",  32'(log_wdata),  32'(data));
        check_eq("sw_grant",   32'(sw_grant),   32'(m_phase == M_SW));
        check_eq("flush_req",  32'(flush_req),  32'(m_phase == M_FULL));
        check_eq("log_ptr",    32'(log_ptr),    32'(m_ptr));
        check_eq("overflow",   32'(overflow),   32'(m_ovf));
        check_eq("drain_done", 32'(drain_done),
                 32'(drain_req && exp_q.size() == 0 && m_phase == M_IDLE));
    endtask

    task automatic model_step();
        bit room;
        if (puc) begin
            model_reset();
            return;
        end
        room = exp_q.size() < DEPTH;
        if (ent_valid && !room) m_ovf = 1;
        case (m_phase)
            M_IDLE: begin
                if (sw_req) m_phase = M_SW;
                else if (exp_q.size() > 0) m_phase = M_SRC;
            end
            M_SW:  if (!sw_req) m_phase = M_IDLE;
            M_SRC: begin
                m_ptr++;
                m_phase = M_DEST;
            end
            M_DEST: begin
                m_ptr++;
                void'(exp_q.pop_front());
                m_phase = (m_ptr == LS) ? M_FULL : M_IDLE;
            end
            M_FULL: begin
                if (flush_ack) begin
                    m_ptr   = 0;
                    m_phase = M_IDLE;
                end
            end
            default: m_phase = M_IDLE;
        endcase
        if (ent_valid && room) exp_q.push_back({ent_src, ent_dest});
    endtask

    // One clock: drive inputs, compare against the model, advance both.
    task automatic cycle(input bit v, input logic [15:0] s, input logic [15:0] d,
                         input bit sw, input bit ack, input bit drn, input bit rst);
        ent_valid = v;
        ent_src   = s;
        ent_dest  = d;
        sw_req    = sw;
        flush_ack = ack;
        drain_req = drn;
        puc       = rst;
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 16'h0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cycle(0, 16'h0, 16'h0, 0, 0, 0, 1);
    endtask

    initial begin
        bit sw_lvl, drn_lvl;
        puc = 1'b1; ent_valid = 0; ent_src = 0; ent_dest = 0;
        sw_req = 0; flush_ack = 0; drain_req = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        puc = 1'b0;
        #1;
        check_eq("rst_ent_ready", 32'(ent_ready), 32'd1);
        check_eq("rst_log_wen",   32'(log_wen),   32'd0);
        check_eq("rst_log_ptr",   32'(log_ptr),   32'd0);
        check_eq("rst_overflow",  32'(overflow),  32'd0);
        check_eq("rst_flush_req", 32'(flush_req), 32'd0);
        check_eq("rst_sw_grant",  32'(sw_grant),  32'd0);

        // Single entry: two writes one cycle after the push.
        cycle(1, 16'hE100, 16'hE200, 0, 0, 0, 0);
        cycle(0, 16'h0, 16'h0, 0, 0, 0, 0);
        check_eq("single_wen_src",  32'(log_wen),   32'd1);
        check_eq("single_data_src", 32'(log_wdata), 32'hE100);
        idle(4);
        check_eq("single_ptr", 32'(log_ptr), 32'd2);

        // Six back-to-back pushes: FIFO fills, overflow sticks, log fills up.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 16'hA000 + 16'(i), 16'hB000 + 16'(i), 0, 0, 0, 0);
        check_eq("burst_overflow", 32'(overflow), 32'd1);
        idle(16);
        check_eq("burst_full", 32'(flush_req), 32'd1);
        cycle(0, 16'h0, 16'h0, 0, 1, 0, 0);
        idle(8);

        // Five spaced entries with LOG_SIZE=8: four fill the log, fifth waits for flush.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 16'hC000 + 16'(i), 16'hD000 + 16'(i), 0, 0, 0, 0);
            idle(2);
        end
        idle(6);
        check_eq("full_flush_req", 32'(flush_req), 32'd1);
        check_eq("full_ptr",       32'(log_ptr),   32'd8);
        cycle(0, 16'h0, 16'h0, 1, 0, 0, 0);
        cycle(0, 16'h0, 16'h0, 0, 1, 0, 0);
        check_eq("flush_ptr", 32'(log_ptr), 32'd0);
        idle(5);
        check_eq("fifth_ptr", 32'(log_ptr), 32'd2);

        // sw_req alongside a push, then sw_req raised mid-entry.
        do_reset();
        cycle(1, 16'h1111, 16'h2222, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 16'h0, 16'h0, 1, 0, 0, 0);
        idle(4);
        cycle(1, 16'h3333, 16'h4444, 0, 0, 0, 0);
        cycle(0, 16'h0, 16'h0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 16'h0, 16'h0, 1, 0, 0, 0);
        idle(3);

        // Drain with two queued entries.
        do_reset();
        cycle(1, 16'h5555, 16'h6666, 0, 0, 1, 0);
        cycle(1, 16'h7777, 16'h8888, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 16'h0, 16'h0, 0, 0, 1, 0);
        check_eq("drain_done_end", 32'(drain_done), 32'd1);

        // puc during WR_SRC abandons the entry.
        do_reset();
        cycle(1, 16'h9999, 16'hAAAA, 0, 0, 0, 0);
        cycle(0, 16'h0, 16'h0, 0, 0, 0, 0);
        cycle(0, 16'h0, 16'h0, 0, 0, 0, 1);
        check_eq("puc_wen",   32'(log_wen),   32'd0);
        check_eq("puc_ptr",   32'(log_ptr),   32'd0);
        check_eq("puc_ready", 32'(ent_ready), 32'd1);
        idle(4);

        // Random traffic.
        sw_lvl  = 0;
        drn_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (sw_lvl) sw_lvl = ($urandom_range(0, 9) < 8);
            else        sw_lvl = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) drn_lvl = ~drn_lvl;
            cycle($urandom_range(0, 1), 16'($urandom), 16'($urandom), sw_lvl,
                  ($urandom_range(0, 3) == 0), drn_lvl, ($urandom_range(0, 399) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
